mpsoc_ahb3_sram_ws: RTL
=======================

MPSOC_AHB3_SRAM_WS -- requirements
Module: mpsoc_ahb3_sram_ws

Interface
REQ-001 SHALL have parameter XLEN, default 64: data width in bits, 32 or 64.
REQ-002 SHALL have parameter PLEN, default 64: address width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: number of XLEN-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 0: data-phase wait cycles per transfer, 0..7.
REQ-005 SHALL have parameter PRIV_BOUNDARY, default 64: word index below which the privileged region lies.
REQ-006 SHALL have port HCLK, input, 1: single clock, all logic rising-edge.
REQ-007 SHALL have port HRESETn, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports HSEL in 1, HADDR in PLEN, HWDATA in XLEN, HWRITE in 1, HSIZE in 3, HBURST in 3, HPROT in 4, HTRANS in 2, HMASTLOCK in 1, HREADY in 1: AHB3-Lite slave inputs.
REQ-009 SHALL have ports HRDATA out XLEN, HREADYOUT out 1, HRESP out 1: AHB3-Lite slave outputs.

Function
REQ-010 SHALL accept a transfer when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; it SHALL register address, HWRITE, HSIZE and HPROT.
REQ-011 SHALL answer IDLE/BUSY or unselected cycles with a zero-wait OKAY: HREADYOUT=1, HRESP=0.
REQ-012 SHALL use FSM states IDLE, WAIT, ERR1, ERR2; accepted legal transfer -> WAIT if WAIT_STATES>0, else data phase completes in the next cycle.
REQ-013 SHALL hold HREADYOUT=0 in WAIT for exactly WAIT_STATES cycles via a down-counter, then drive HREADYOUT=1 for one cycle and return to IDLE or accept the next transfer.
REQ-014 SHALL sample HWDATA and commit the write in the cycle HREADYOUT=1, with byte enables from HSIZE and HADDR[log2(XLEN/8)-1:0].
REQ-015 SHALL drive HRDATA with the full addressed word, valid in the cycle HREADYOUT=1.
REQ-016 SHALL forward write data so that a read of the same word directly following a write returns the new bytes merged with the old word, with no added wait.
REQ-017 SHALL treat word index >= MEM_DEPTH, HSIZE > log2(XLEN/8), or an address misaligned to HSIZE as an error; it SHALL not write memory.
REQ-018 SHALL give a two-cycle error response: ERR1 drives HRESP=1, HREADYOUT=0; ERR2 drives HRESP=1, HREADYOUT=1; then IDLE.
REQ-019 SHALL, when an error is decoded, skip WAIT and enter ERR1 directly.
REQ-020 SHALL drive HRDATA=0 on erroring reads.
REQ-021 SHALL ignore HBURST and HMASTLOCK; back-to-back SEQ beats SHALL each incur WAIT_STATES.
REQ-022 SHALL leave memory contents uninitialised by reset.

Reset
REQ-023 SHALL, on HRESETn=0 at any time including mid-WAIT or mid-ERR, force state IDLE, wait counter 0, HREADYOUT=1, HRESP=0 and HRDATA=0.
REQ-024 SHALL cancel any pending write on reset, with no memory update.
REQ-025 SHALL release reset with the first transfer acceptable in the first HCLK edge after HRESETn rises.

Configuration
REQ-026 SHALL use macro MPSOC_AHB3_SRAM_PRIV_CHECK_EN.
REQ-027 SHALL, when the macro is defined, treat an access with HPROT[1]=0 (user) to a word index < PRIV_BOUNDARY as an error under REQ-018, with no write.
REQ-028 SHALL, when the macro is undefined, ignore HPROT entirely; such accesses complete OKAY.

Verification
REQ-029 WAIT_STATES=0: write 0x0123456789ABCDEF to 0x10, then read 0x10 back-to-back -> read returns 0x0123456789ABCDEF, HREADYOUT never low.
REQ-030 WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, then 1 with data.
REQ-031 Byte write HSIZE=0 of 0xAA to 0x13 over word 0 -> word at 0x10 reads 0x00000000AA000000.
REQ-032 Read at word 256 (MEM_DEPTH=256) -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then OKAY; HRDATA=0.
REQ-033 Macro defined: user write (HPROT=0001) to 0x0 -> two-cycle ERROR and memory unchanged; macro undefined -> OKAY and write lands.
REQ-034 HRESETn pulsed low during the 2nd wait cycle of a write -> HREADYOUT=1, HRESP=0, target word unchanged.

Source files
------------

// File: rtl/mpsoc_ahb3_sram_ws.sv
// ---------------------------------------------------------------------------
// mpsoc_ahb3_sram_ws
//
// AHB3-Lite slave wrapping an on-chip SRAM of MEM_DEPTH words of XLEN bits,
// with a programmable number of data-phase wait states and a two-cycle
// ERROR response for illegal accesses.
//
// Parameters
//   XLEN          data width in bits (32 or 64)
//   PLEN          address width in bits
//   MEM_DEPTH     number of XLEN-bit words
//   WAIT_STATES   HREADYOUT-low cycles inserted per legal transfer (0..7)
//   PRIV_BOUNDARY word index below which the privileged region lies
//
// Ports
//   HCLK, HRESETn           clock (rising edge), asynchronous active-low reset
//   HSEL .. HREADY          AHB3-Lite slave address/data-phase inputs
//   HRDATA, HREADYOUT, HRESP AHB3-Lite slave outputs
//
// Build option
//   MPSOC_AHB3_SRAM_PRIV_CHECK_EN  when defined, user-mode (HPROT[1]=0)
//   accesses below PRIV_BOUNDARY get an ERROR response and never write.
//   HBURST and HMASTLOCK are accepted for interface completeness only.
// ---------------------------------------------------------------------------
module mpsoc_ahb3_sram_ws #(
    parameter int XLEN          = 64,
    parameter int PLEN          = 64,
    parameter int MEM_DEPTH     = 256,
    parameter int WAIT_STATES   = 0,
    parameter int PRIV_BOUNDARY = 64
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic [XLEN-1:0] HRDATA,
    output logic            HREADYOUT,
    output logic            HRESP
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);
    localparam int AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [PLEN-1:0] DEPTH_L = PLEN'(MEM_DEPTH);
    localparam logic [2:0]      WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                act_q, act_d;
    logic                write_q, write_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [NBYTES-1:0]   be_q, be_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [XLEN-1:0]     mem_q [MEM_DEPTH];

    logic                readyOut;
    logic                accept;
    logic                complete;
    logic                commit;
    logic [PLEN-1:0]     wordAddr;
    logic [AW-1:0]       accIdx;
    logic                decErr;
    logic [NBYTES-1:0]   decBe;
    logic [XLEN-1:0]     fwdWord;
    int                  sizeBytes;
    int                  byteOff;
    logic [OFFW-1:0]     alignMask;

    // Only IDLE and ERR2 let the current data phase end; a legal transfer
    // completes in an IDLE cycle while act_q marks it as still outstanding.
    assign readyOut  = (state_q == IDLE) || (state_q == ERR2);
    assign HREADYOUT = readyOut;
    assign HRESP     = (state_q == ERR1) || (state_q == ERR2);
    assign accept    = HSEL && HREADY && HTRANS[1] && readyOut;
    assign complete  = (state_q == IDLE) && act_q;
    assign commit    = complete && write_q;
    assign HRDATA    = (complete && !write_q) ? rdata_q : '0;
    assign wordAddr  = HADDR >> OFFW;
    assign accIdx    = HADDR[OFFW +: AW];

    // Address-phase decode: error classification and byte lanes.
    always_comb begin
        decErr    = 1'b0;
        decBe     = '0;
        sizeBytes = 1 << HSIZE;
        byteOff   = int'(HADDR[OFFW-1:0]);
        alignMask = OFFW'(sizeBytes - 1);
        if (wordAddr >= DEPTH_L) begin
            decErr = 1'b1;
        end
        if (int'(HSIZE) > OFFW) begin
            decErr = 1'b1;
        end else if ((HADDR[OFFW-1:0] & alignMask) != '0) begin
            decErr = 1'b1;
        end
`ifdef MPSOC_AHB3_SRAM_PRIV_CHECK_EN
        if (!HPROT[1] && (wordAddr < PLEN'(PRIV_BOUNDARY))) begin
            decErr = 1'b1;
        end
`endif
        for (int i = 0; i < NBYTES; i++) begin
            decBe[i] = (i >= byteOff) && (i < byteOff + sizeBytes);
        end
    end

    // The read word is captured at the accepting edge. A write to the same
    // word may commit on that very edge, so its bytes are merged in here.
    always_comb begin
        fwdWord = mem_q[accIdx];
        if (commit && (idx_q == accIdx)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be_q[i]) begin
                    fwdWord[8*i +: 8] = HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Next-state logic; a new transfer can only be accepted from IDLE or ERR2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        write_d = write_q;
        idx_d   = idx_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (complete) begin
                    act_d = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ERR1:    state_d = ERR2;
            ERR2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (decErr) begin
                state_d = ERR1;
                act_d   = 1'b0;
                rdata_d = '0;
            end else begin
                act_d   = 1'b1;
                write_d = HWRITE;
                idx_d   = accIdx;
                be_d    = decBe;
                rdata_d = fwdWord;
                if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                    cnt_d   = WS_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            act_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array: deliberately not reset; writes are gated by act_q, which
    // reset clears, so a write cut off by reset never lands.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule
